// File: rtl/ecc163_pkg.sv
// ecc163_pkg: shared constants, types and GF(2^163) helpers for the sect163r2
// Lopez-Dahab to affine conversion datapath.
//   M              field degree
//   POLY           reduction polynomial t^163 + t^7 + t^6 + t^3 + 1 (M+1 bits)
//   CURVE_A/B      sect163r2 curve coefficients
//   GEN_X/GEN_Y    sect163r2 base point
//   ld_point_t     projective (X,Y,Z) payload
//   conv_state_t   top-level FSM states
//   inv_state_t    Itoh-Tsujii sequencer states
package ecc163_pkg;

  localparam int unsigned M      = 163;
  localparam int unsigned STEP_W = 4;
  localparam int unsigned SQ_W   = 7;
  localparam int unsigned MCNT_W = 8;

  localparam logic [M:0]   POLY    = {1'b1, 155'b0, 8'hC9};
  localparam logic [M-1:0] CURVE_A = 163'h1;
  localparam logic [M-1:0] CURVE_B = 163'h20A601907B8C953CA1481EB10512F78744A3205FD;
  localparam logic [M-1:0] GEN_X   = 163'h3F0EBA16286A2D57EA0991168D4994637E8343E36;
  localparam logic [M-1:0] GEN_Y   = 163'h0D51FBC6C71A0094FA2CDD545B11C5C0C797324F1;

  // Index of the last multiply in the addition chain 1,2,4,5,10,20,40,80,81,162
  localparam logic [STEP_W-1:0] INV_LAST_STEP = 4'd8;

  typedef struct packed {
    logic [M-1:0] x;
    logic [M-1:0] y;
    logic [M-1:0] z;
  } ld_point_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHK,
    ST_INV,
    ST_PX,
    ST_PZ2,
    ST_PY,
    ST_FIN
  } conv_state_t;

  typedef enum logic [1:0] {
    IV_IDLE,
    IV_SQR,
    IV_MUL,
    IV_LAST
  } inv_state_t;

  // Fold bits 2M-2..M back into the field using t^163 = t^7 + t^6 + t^3 + 1
  function automatic logic [M-1:0] gf_reduce(input logic [2*M-2:0] v_in);
    logic [2*M-2:0] v;
    v = v_in;
    for (int unsigned i = 2*M-2; i >= M; i--) begin
      if (v[i]) v[i -: M+1] = v[i -: M+1] ^ POLY;
    end
    return v[M-1:0];
  endfunction

  function automatic logic [M-1:0] gf_mul(input logic [M-1:0] a, input logic [M-1:0] b);
    logic [2*M-2:0] acc;
    acc = '0;
    for (int unsigned i = 0; i < M; i++) begin
      if (b[i]) acc = acc ^ ((2*M-1)'(a) << i);
    end
    return gf_reduce(acc);
  endfunction

  // Squaring in characteristic 2 is bit interleaving with zeros, then reduction
  function automatic logic [M-1:0] gf_sqr(input logic [M-1:0] a);
    logic [2*M-2:0] sp;
    sp = '0;
    for (int unsigned i = 0; i < M; i++) begin
      sp[2*i] = a[i];
    end
    return gf_reduce(sp);
  endfunction

  // Number of squarings that precede each multiply of the chain
  function automatic logic [SQ_W-1:0] inv_sq_len(input logic [STEP_W-1:0] step);
    logic [SQ_W-1:0] n;
    case (step)
      4'd0:    n = 7'd1;
      4'd1:    n = 7'd2;
      4'd2:    n = 7'd1;
      4'd3:    n = 7'd5;
      4'd4:    n = 7'd10;
      4'd5:    n = 7'd20;
      4'd6:    n = 7'd40;
      4'd7:    n = 7'd1;
      4'd8:    n = 7'd81;
      default: n = 7'd1;
    endcase
    return n;
  endfunction

  // Steps 4->5 and 80->81 multiply by beta_1 = Z instead of the run's base value
  function automatic logic inv_use_z(input logic [STEP_W-1:0] step);
    return (step == 4'd2) || (step == 4'd7);
  endfunction

endpackage

// File: rtl/gf2m_inv163.sv
// gf2m_inv163: Itoh-Tsujii inversion in GF(2^163) over the addition chain
// 1,2,4,5,10,20,40,80,81,162 using beta_(i+j) = beta_i^(2^j) * beta_j, followed
// by one final squaring: zinv = beta_162^2 = Z^(2^163-2).
//   clk, rst  clock, synchronous active-high reset
//   start     begin inversion of z (sampled only when idle)
//   z         operand
//   done      one-cycle pulse, zinv valid from this cycle on
//   zinv      z^-1 (held until the next inversion completes)
module gf2m_inv163
  import ecc163_pkg::*;
#(
  parameter int unsigned MULT_LAT = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [M-1:0] z,
  output logic         done,
  output logic [M-1:0] zinv
);

  inv_state_t        state, state_nx;
  logic [M-1:0]      beta, beta_nx;
  logic [M-1:0]      base, base_nx;
  logic [M-1:0]      z1, z1_nx;
  logic [STEP_W-1:0] step, step_nx;
  logic [SQ_W-1:0]   sq_cnt, sq_cnt_nx;
  logic [MCNT_W-1:0] mcnt, mcnt_nx;
  logic [M-1:0]      zinv_nx;
  logic              done_nx;

  logic              mult_load_c;
  logic [M-1:0]      mult_a_c;
  logic [M-1:0]      mult_b_c;
  logic [M-1:0]      mult_p_c;
  logic [M-1:0]      sq_c;

  gf2m_mult163 u_mult (
    .clk  (clk),
    .rst  (rst),
    .load (mult_load_c),
    .a    (mult_a_c),
    .b    (mult_b_c),
    .p_c  (mult_p_c)
  );

  squerer_163 u_sqr (
    .a    (beta),
    .sq_c (sq_c)
  );

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IV_IDLE;
      beta   <= '0;
      base   <= '0;
      z1     <= '0;
      step   <= '0;
      sq_cnt <= '0;
      mcnt   <= '0;
      zinv   <= '0;
      done   <= 1'b0;
    end else begin
      state  <= state_nx;
      beta   <= beta_nx;
      base   <= base_nx;
      z1     <= z1_nx;
      step   <= step_nx;
      sq_cnt <= sq_cnt_nx;
      mcnt   <= mcnt_nx;
      zinv   <= zinv_nx;
      done   <= done_nx;
    end
  end

  // Sequencer: a run of squarings, then one multiply, per chain step
  always_comb begin
    state_nx    = state;
    beta_nx     = beta;
    base_nx     = base;
    z1_nx       = z1;
    step_nx     = step;
    sq_cnt_nx   = sq_cnt;
    mcnt_nx     = mcnt;
    zinv_nx     = zinv;
    done_nx     = 1'b0;
    mult_load_c = 1'b0;
    // The last square of a run feeds the multiplier directly on the same edge
    mult_a_c    = sq_c;
    mult_b_c    = inv_use_z(step) ? z1 : base;

    case (state)
      IV_IDLE: begin
        if (start) begin
          beta_nx   = z;
          base_nx   = z;
          z1_nx     = z;
          step_nx   = '0;
          sq_cnt_nx = inv_sq_len(4'd0) - 7'd1;
          state_nx  = IV_SQR;
        end
      end
      IV_SQR: begin
        beta_nx = sq_c;
        if (sq_cnt == '0) begin
          mult_load_c = 1'b1;
          mcnt_nx     = '0;
          state_nx    = IV_MUL;
        end else begin
          sq_cnt_nx = sq_cnt - 7'd1;
        end
      end
      IV_MUL: begin
        if (mcnt == MCNT_W'(MULT_LAT)) begin
          beta_nx = mult_p_c;
          base_nx = mult_p_c;
          mcnt_nx = '0;
          if (step == INV_LAST_STEP) begin
            state_nx = IV_LAST;
          end else begin
            step_nx   = step + 4'd1;
            sq_cnt_nx = inv_sq_len(step + 4'd1) - 7'd1;
            state_nx  = IV_SQR;
          end
        end else begin
          mcnt_nx = mcnt + 8'd1;
        end
      end
      IV_LAST: begin
        zinv_nx  = sq_c;
        done_nx  = 1'b1;
        state_nx = IV_IDLE;
      end
      default: state_nx = IV_IDLE;
    endcase
  end

endmodule

// File: rtl/gf2m_mult163.sv
// gf2m_mult163: GF(2^163) multiplier with registered operands. The product is
// a multi-cycle combinational path; the caller samples p_c a fixed number of
// wait cycles after load.
//   clk, rst  clock, synchronous active-high reset
//   load      capture a and b into the operand registers
//   a, b      field operands
//   p_c       a_q * b_q mod f (combinational from the operand registers)
module gf2m_mult163
  import ecc163_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [M-1:0] a,
  input  logic [M-1:0] b,
  output logic [M-1:0] p_c
);

  logic [M-1:0] a_q;
  logic [M-1:0] b_q;

  // Operand registers
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q <= '0;
      b_q <= '0;
    end else if (load) begin
      a_q <= a;
      b_q <= b;
    end
  end

  assign p_c = gf_mul(a_q, b_q);

endmodule

// File: rtl/squerer_163.sv
// squerer_163: combinational GF(2^163) squarer; the caller registers the operand
// and takes the result on the following edge.
//   a     field operand
//   sq_c  a^2 mod f
module squerer_163
  import ecc163_pkg::*;
(
  input  logic [M-1:0] a,
  output logic [M-1:0] sq_c
);

  assign sq_c = gf_sqr(a);

endmodule

// File: rtl/ld163_to_affine.sv
// ld163_to_affine: converts a sect163r2 Lopez-Dahab point (X,Y,Z) to affine
// x = X/Z, y = Y/Z^2; Z == 0 is reported as the point at infinity.
//   clk              clock
//   rst              synchronous active-high reset, aborts a conversion
//   start            request conversion, sampled only in IDLE
//   X_in/Y_in/Z_in   projective coordinates, latched when start is accepted
//   x_aff/y_aff      affine result, valid with done and held until next start
//   inf              1 when the input had Z == 0, valid with done
//   busy             high from the cycle after start acceptance until done
//   done             one-cycle completion pulse
module ld163_to_affine
  import ecc163_pkg::*;
#(
  parameter int unsigned MULT_LAT = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [M-1:0] X_in,
  input  logic [M-1:0] Y_in,
  input  logic [M-1:0] Z_in,
  output logic [M-1:0] x_aff,
  output logic [M-1:0] y_aff,
  output logic         inf,
  output logic         busy,
  output logic         done
);

  conv_state_t       state, state_nx;
  ld_point_t         pt, pt_nx;
  logic              is_inf, is_inf_nx;
  logic [MCNT_W-1:0] mcnt, mcnt_nx;
  logic [M-1:0]      x_aff_nx;
  logic [M-1:0]      y_aff_nx;
  logic              inf_nx;
  logic              busy_nx;
  logic              done_nx;

  logic              inv_start_c;
  logic              inv_done;
  logic [M-1:0]      zinv;
  logic [M-1:0]      zinv2_c;
  logic              mult_load_c;
  logic [M-1:0]      mult_a_c;
  logic [M-1:0]      mult_b_c;
  logic [M-1:0]      mult_p_c;

  gf2m_inv163 #(
    .MULT_LAT (MULT_LAT)
  ) u_inv (
    .clk   (clk),
    .rst   (rst),
    .start (inv_start_c),
    .z     (pt.z),
    .done  (inv_done),
    .zinv  (zinv)
  );

  gf2m_mult163 u_mult (
    .clk  (clk),
    .rst  (rst),
    .load (mult_load_c),
    .a    (mult_a_c),
    .b    (mult_b_c),
    .p_c  (mult_p_c)
  );

  squerer_163 u_sqr (
    .a    (zinv),
    .sq_c (zinv2_c)
  );

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      pt     <= '0;
      is_inf <= 1'b0;
      mcnt   <= '0;
      x_aff  <= '0;
      y_aff  <= '0;
      inf    <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      state  <= state_nx;
      pt     <= pt_nx;
      is_inf <= is_inf_nx;
      mcnt   <= mcnt_nx;
      x_aff  <= x_aff_nx;
      y_aff  <= y_aff_nx;
      inf    <= inf_nx;
      busy   <= busy_nx;
      done   <= done_nx;
    end
  end

  // Conversion control: infinity check, inversion, then the two products
  always_comb begin
    state_nx    = state;
    pt_nx       = pt;
    is_inf_nx   = is_inf;
    mcnt_nx     = mcnt;
    x_aff_nx    = x_aff;
    y_aff_nx    = y_aff;
    inf_nx      = inf;
    busy_nx     = busy;
    done_nx     = 1'b0;
    inv_start_c = 1'b0;
    mult_load_c = 1'b0;
    mult_a_c    = pt.x;
    mult_b_c    = zinv;

    case (state)
      ST_IDLE: begin
        if (start) begin
          pt_nx.x  = X_in;
          pt_nx.y  = Y_in;
          pt_nx.z  = Z_in;
          busy_nx  = 1'b1;
          state_nx = ST_CHK;
        end
      end
      ST_CHK: begin
        is_inf_nx = (pt.z == '0);
        if (pt.z == '0) begin
          state_nx = ST_FIN;
        end else begin
          inv_start_c = 1'b1;
          state_nx    = ST_INV;
        end
      end
      ST_INV: begin
        if (inv_done) begin
          mult_load_c = 1'b1;
          mcnt_nx     = '0;
          state_nx    = ST_PX;
        end
      end
      ST_PX: begin
        if (mcnt == MCNT_W'(MULT_LAT)) begin
          x_aff_nx = mult_p_c;
          mcnt_nx  = '0;
          state_nx = ST_PZ2;
        end else begin
          mcnt_nx = mcnt + 8'd1;
        end
      end
      ST_PZ2: begin
        // Zinv^2 goes straight into the multiplier operand register
        mult_load_c = 1'b1;
        mult_a_c    = pt.y;
        mult_b_c    = zinv2_c;
        mcnt_nx     = '0;
        state_nx    = ST_PY;
      end
      ST_PY: begin
        if (mcnt == MCNT_W'(MULT_LAT)) begin
          y_aff_nx = mult_p_c;
          mcnt_nx  = '0;
          state_nx = ST_FIN;
        end else begin
          mcnt_nx = mcnt + 8'd1;
        end
      end
      ST_FIN: begin
        done_nx  = 1'b1;
        busy_nx  = 1'b0;
        inf_nx   = is_inf;
        if (is_inf) begin
          x_aff_nx = '0;
          y_aff_nx = '0;
        end
        state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_ld163_to_affine.sv
// tb_ld163_to_affine: self-checking bench for ld163_to_affine. A driver issues
// conversions and pushes model results onto a scoreboard queue; a monitor pops
// and compares on every done pulse (result, inf, busy and latency).
`timescale 1ns/1ps
module tb_ld163_to_affine;

  localparam int unsigned MULT_LAT = 3;
  // 163 squarings, 11 multiplies of MULT_LAT+1 cycles, plus CHK, inverse hand-off and FIN
  localparam int LAT_NZ  = 163 + 11 * (MULT_LAT + 1) + 3;
  localparam int LAT_Z   = 2;
  localparam int LAT_MAX = 220;

  localparam logic [163:0] F  = {1'b1, 155'b0, 8'b1100_1001};
  localparam logic [162:0] GX = 163'h3F0EBA16286A2D57EA0991168D4994637E8343E36;
  localparam logic [162:0] GY = 163'h0D51FBC6C71A0094FA2CDD545B11C5C0C797324F1;

  typedef struct {
    logic [162:0] x;
    logic [162:0] y;
    logic         inf;
    time          t0;
    int           lat;
  } exp_t;

  logic         clk;
  logic         rst;
  logic         start;
  logic [162:0] X_in, Y_in, Z_in;
  logic [162:0] x_aff, y_aff;
  logic         inf, busy, done;

  exp_t exp_q[$];
  int   vectors;
  int   miscompares;
  int   n_done;

  ld163_to_affine #(.MULT_LAT(MULT_LAT)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .X_in  (X_in),
    .Y_in  (Y_in),
    .Z_in  (Z_in),
    .x_aff (x_aff),
    .y_aff (y_aff),
    .inf   (inf),
    .busy  (busy),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference field arithmetic: MSB-first shift-and-add with per-step reduction
  function automatic logic [162:0] m_mul(input logic [162:0] a, input logic [162:0] b);
    logic [163:0] r;
    r = '0;
    for (int i = 162; i >= 0; i--) begin
      r = {r[162:0], 1'b0};
      if (r[163]) r = r ^ F;
      if (b[i]) r[162:0] = r[162:0] ^ a;
    end
    return r[162:0];
  endfunction

  // Fermat inverse: z^(2^163-2) = product of z^(2^k) for k = 1..162
  function automatic logic [162:0] m_inv(input logic [162:0] z);
    logic [162:0] r, s;
    r = 163'd1;
    s = z;
    for (int k = 1; k <= 162; k++) begin
      s = m_mul(s, s);
      r = m_mul(r, s);
    end
    return r;
  endfunction

  function automatic logic [162:0] rand163();
    logic [191:0] r;
    r = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    return r[162:0];
  endfunction

  task automatic check(input string name, input logic [162:0] act, input logic [162:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding request
  always @(negedge clk) begin
    exp_t e;
    int   lat;
    if (rst === 1'b0 && done === 1'b1) begin
      n_done++;
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL stray_done: done with no outstanding request (t=%0t)", $time);
      end else begin
        e   = exp_q.pop_front();
        lat = int'(($time - e.t0) / 10);
        check("x_aff", x_aff, e.x);
        check("y_aff", y_aff, e.y);
        check("inf", 163'(inf), 163'(e.inf));
        check("latency", 163'(lat), 163'(e.lat));
        check("latency_max", 163'(lat <= LAT_MAX), 163'(1'b1));
        check("busy_at_done", 163'(busy), 163'(1'b0));
      end
    end
  end

  // Drive one request now; it is accepted at the next rising edge
  task automatic convert(input logic [162:0] x, input logic [162:0] y, input logic [162:0] z);
    exp_t         e;
    logic [162:0] zi;
    X_in  = x;
    Y_in  = y;
    Z_in  = z;
    start = 1'b1;
    if (z == '0) begin
      e.x   = '0;
      e.y   = '0;
      e.inf = 1'b1;
      e.lat = LAT_Z;
    end else begin
      zi    = m_inv(z);
      e.x   = m_mul(x, zi);
      e.y   = m_mul(y, m_mul(zi, zi));
      e.inf = 1'b0;
      e.lat = LAT_NZ;
    end
    @(posedge clk);
    e.t0 = $time;
    exp_q.push_back(e);
    #1;
    start = 1'b0;
    check("busy_after_start", 163'(busy), 163'(1'b1));
  endtask

  // Returns just after the negedge of the done cycle, or flags a timeout
  task automatic wait_done(input string name);
    int target;
    target = n_done + 1;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      #1;
      if (n_done >= target) break;
    end
    if (n_done < target) begin
      vectors++;
      miscompares++;
      $display("FAIL %s_timeout: no done within 300 cycles (t=%0t)", name, $time);
      exp_q.delete();
    end
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_x_aff"}, x_aff, '0);
    check({tag, "_y_aff"}, y_aff, '0);
    check({tag, "_inf"}, 163'(inf), 163'(1'b0));
    check({tag, "_busy"}, 163'(busy), 163'(1'b0));
    check({tag, "_done"}, 163'(done), 163'(1'b0));
  endtask

  initial begin
    int n0;
    vectors     = 0;
    miscompares = 0;
    n_done      = 0;
    rst   = 1'b1;
    start = 1'b0;
    X_in  = '0;
    Y_in  = '0;
    Z_in  = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check_reset_state("reset");

    // Small operands: 3/3 = 1 and 5/(t+1)^2 = 1
    @(negedge clk);
    convert(163'h3, 163'h5, 163'h3);
    wait_done("t1");
    check("t1_x_is_1", x_aff, 163'd1);
    check("t1_y_is_1", y_aff, 163'd1);

    // Generator with Z = 1
    @(negedge clk);
    convert(GX, GY, 163'd1);
    wait_done("t2");
    check("t2_x_is_gx", x_aff, GX);
    check("t2_y_is_gy", y_aff, GY);

    // Generator scaled by Z = t; start raised during the done cycle
    convert(m_mul(GX, 163'h2), m_mul(GY, 163'h4), 163'h2);
    wait_done("t3");
    check("t3_x_is_gx", x_aff, GX);
    check("t3_y_is_gy", y_aff, GY);

    // Point at infinity
    @(negedge clk);
    convert(rand163(), rand163(), '0);
    wait_done("t4");

    // Start re-pulsed mid-conversion with different operands must be ignored
    @(negedge clk);
    convert(GX, GY, 163'h3);
    repeat (49) @(negedge clk);
    X_in  = rand163();
    Y_in  = rand163();
    Z_in  = rand163();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done("t5");
    n0 = n_done;
    repeat (30) @(negedge clk);
    check("t5_single_done", 163'(n_done), 163'(n0));

    // Reset at cycle 100 aborts the conversion with no done afterwards
    @(negedge clk);
    convert(rand163(), rand163(), rand163() | 163'd1);
    repeat (99) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    check_reset_state("midrst");
    n0 = n_done;
    repeat (250) @(negedge clk);
    check("t6_no_stray_done", 163'(n_done), 163'(n0));
    @(negedge clk);
    convert(163'h3, 163'h5, 163'h3);
    wait_done("t6");
    check("t6_x_is_1", x_aff, 163'd1);
    check("t6_y_is_1", y_aff, 163'd1);

    // Random points, alternating gap and back-to-back starts, one Z = 0
    for (int i = 0; i < 8; i++) begin
      logic [162:0] rz;
      rz = (i == 3) ? 163'd0 : rand163();
      if (i % 2 == 0) @(negedge clk);
      convert(rand163(), rand163(), rz);
      wait_done("rand");
    end

    repeat (5) @(negedge clk);
    check("queue_drained", 163'(exp_q.size()), 163'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
